// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM single-port memory arbiter:
// owner encodings, the default starvation limit and a grant-to-owner helper.
package mem_arbiter_pkg;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_FETCH = 2'd1;
    localparam logic [1:0] OWN_DRD   = 2'd2;
    localparam logic [1:0] OWN_DWR   = 2'd3;

    // Map this cycle's grant to the owner that returns a response next cycle.
    function automatic logic [1:0] owner_of(input logic i_gnt, input logic d_gnt, input logic d_we);
        if (d_gnt) begin
            return d_we ? OWN_DWR : OWN_DRD;
        end
        if (i_gnt) begin
            return OWN_FETCH;
        end
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; at_limit lets fetch
// win the next conflict with the data port.
module arb_starve_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic srst,
    input  logic i_req,
    input  logic i_gnt,
    output logic at_limit
);

    localparam logic [3:0] LIMIT_V = 4'(LIMIT);

    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (!i_req || i_gnt) begin
            cnt_next = '0;
        end else if (cnt_reg != LIMIT_V) begin
            cnt_next = cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign at_limit = (cnt_reg == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the IF and MEM stage ports onto one synchronous RAM: data has
// priority, a starvation counter guarantees fetch progress, responses come one cycle later.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iReq,
    input  logic [31:0] iAddr,
    output logic        iGnt,
    output logic        iValid,
    output logic [31:0] iData,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWData,
    output logic        dGnt,
    output logic        dValid,
    output logic [31:0] dRData,
    output logic        ramCe,
    output logic        ramWe,
    output logic [31:0] ramAddr,
    output logic [31:0] ramWData,
    input  logic [31:0] ramRData,
    output logic        stall
);

    logic       fetch_priority;
    logic [1:0] owner_reg;
    logic [1:0] owner_next;

    arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk     (clk),
        .srst    (rst),
        .i_req   (iReq),
        .i_gnt   (iGnt),
        .at_limit(fetch_priority)
    );

    assign dGnt  = dReq & ~(iReq & fetch_priority);
    assign iGnt  = iReq & ~dGnt;
    assign stall = iReq & ~iGnt;

    assign ramCe    = iGnt | dGnt;
    assign ramWe    = dGnt & dWe;
    assign ramAddr  = dGnt ? dAddr : (iGnt ? iAddr : 32'd0);
    assign ramWData = dGnt ? dWData : 32'd0;

    assign owner_next = owner_of(iGnt, dGnt, dWe);

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg <= OWN_NONE;
        end else begin
            owner_reg <= owner_next;
        end
    end

    // Responses are suppressed while reset is held so an in-flight access is dropped.
    assign iValid = ~rst & (owner_reg == OWN_FETCH);
    assign dValid = ~rst & ((owner_reg == OWN_DRD) | (owner_reg == OWN_DWR));
    assign iData  = iValid ? ramRData : 32'd0;
    assign dRData = (~rst & (owner_reg == OWN_DRD)) ? ramRData : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand sequences for
// reset and starvation corners, then held-request random traffic against a reference model.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    typedef struct packed {
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        chk_tbl;
        logic        chk_resp;
        logic        e_ig;
        logic        e_dg;
        logic        e_st;
        logic        e_iv;
        logic [31:0] e_id;
        logic        e_dv;
        logic [31:0] e_dr;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        iReq, dReq, dWe;
    logic [31:0] iAddr, dAddr, dWData;
    logic        iGnt, iValid, dGnt, dValid, ramCe, ramWe, stall;
    logic [31:0] iData, dRData, ramAddr, ramWData, ramRData;

    logic [31:0] ram [0:255];
    logic [31:0] ref_mem [0:255];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int denied = 0;
    int pend_kind = 0;
    logic [31:0] pend_data = '0;
    logic last_ig, last_dg;
    vec_t tbl[$];

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt), .iValid(iValid), .iData(iData),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData),
        .dGnt(dGnt), .dValid(dValid), .dRData(dRData),
        .ramCe(ramCe), .ramWe(ramWe), .ramAddr(ramAddr), .ramWData(ramWData),
        .ramRData(ramRData), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ramCe) begin
            if (ramWe) ram[ramAddr[9:2]] <= ramWData;
            else       ramRData <= ram[ramAddr[9:2]];
        end
    end

    function automatic int idx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw, input logic [31:0] da,
                                input logic [31:0] dd, input logic eig, input logic edg,
                                input logic est, input logic resp, input logic eiv,
                                input logic [31:0] eid, input logic edv, input logic [31:0] edr);
        vec_t v;
        v = '0;
        v.rst = r; v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw;
        v.d_addr = da; v.d_wdata = dd; v.chk_tbl = 1'b1; v.chk_resp = resp;
        v.e_ig = eig; v.e_dg = edg; v.e_st = est;
        v.e_iv = eiv; v.e_id = eid; v.e_dv = edv; v.e_dr = edr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic run_cycle(input vec_t v);
        logic e_ig, e_dg, e_st, e_iv, e_dv;
        logic [31:0] e_id, e_dr, e_addr;
        rst = v.rst; iReq = v.i_req; iAddr = v.i_addr;
        dReq = v.d_req; dWe = v.d_we; dAddr = v.d_addr; dWData = v.d_wdata;
        @(negedge clk);
        // Reference rules: data wins a conflict unless fetch has been refused LIMIT times running.
        e_ig   = v.i_req && (!v.d_req || denied >= LIMIT);
        e_dg   = v.d_req && !e_ig;
        e_st   = v.i_req && !e_ig;
        e_iv   = !v.rst && pend_kind == 1;
        e_dv   = !v.rst && (pend_kind == 2 || pend_kind == 3);
        e_id   = e_iv ? pend_data : 32'd0;
        e_dr   = (e_dv && pend_kind == 2) ? pend_data : 32'd0;
        e_addr = e_dg ? v.d_addr : (e_ig ? v.i_addr : 32'd0);
        chk("iGnt", 32'(iGnt), 32'(e_ig));
        chk("dGnt", 32'(dGnt), 32'(e_dg));
        chk("stall", 32'(stall), 32'(e_st));
        chk("ramCe", 32'(ramCe), 32'(e_ig | e_dg));
        chk("ramWe", 32'(ramWe), 32'(e_dg & v.d_we));
        chk("ramAddr", ramAddr, e_addr);
        if (e_dg && v.d_we) chk("ramWData", ramWData, v.d_wdata);
        chk("iValid", 32'(iValid), 32'(e_iv));
        chk("iData", iData, e_id);
        chk("dValid", 32'(dValid), 32'(e_dv));
        chk("dRData", dRData, e_dr);
        if (v.chk_tbl) begin
            chk("tbl_iGnt", 32'(iGnt), 32'(v.e_ig));
            chk("tbl_dGnt", 32'(dGnt), 32'(v.e_dg));
            chk("tbl_stall", 32'(stall), 32'(v.e_st));
            if (v.chk_resp) begin
                chk("tbl_iValid", 32'(iValid), 32'(v.e_iv));
                chk("tbl_iData", iData, v.e_id);
                chk("tbl_dValid", 32'(dValid), 32'(v.e_dv));
                chk("tbl_dRData", dRData, v.e_dr);
            end
        end
        last_ig = iGnt;
        last_dg = dGnt;
        $display("cyc %0d rst=%b ireq=%b ignt=%b dreq=%b dwe=%b dgnt=%b stall=%b iv=%b id=%h dv=%b dr=%h",
                 cyc, v.rst, v.i_req, iGnt, v.d_req, v.d_we, dGnt, stall, iValid, iData, dValid, dRData);
        @(posedge clk);
        if (e_dg && v.d_we) ref_mem[idx(v.d_addr)] = v.d_wdata;
        if (v.rst) begin
            pend_kind = 0;
        end else if (e_ig) begin
            pend_kind = 1; pend_data = ref_mem[idx(v.i_addr)];
        end else if (e_dg) begin
            pend_kind = v.d_we ? 3 : 2;
            pend_data = v.d_we ? 32'd0 : ref_mem[idx(v.d_addr)];
        end else begin
            pend_kind = 0;
        end
        if (v.rst || !v.i_req || e_ig) denied = 0;
        else if (denied < LIMIT) denied++;
        cyc++;
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t r;
        logic pi, pd, rwe;
        logic [31:0] ria, rda, rdw;
        for (int k = 0; k < 256; k++) begin
            ram[k] = 32'hA500_0000 ^ (32'(k) * 32'h0101_0101);
            ref_mem[k] = ram[k];
        end
        ram[4] = 32'h2402_000A;
        ref_mem[4] = 32'h2402_000A;
        rst = 1'b1; iReq = 0; dReq = 0; dWe = 0; iAddr = 0; dAddr = 0; dWData = 0;
        @(posedge clk);
        #1;

        // rst ir iaddr  dr dw daddr dwdata  eig edg est resp eiv eid  edv edr
        tbl.push_back(mk(1, 0, 0,     0, 0, 0,     0,            0, 0, 0, 1, 0, 0,            0, 0));
        tbl.push_back(mk(0, 1, 32'h10, 0, 0, 0,    0,            1, 0, 0, 1, 0, 0,            0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0,            0, 0, 0, 1, 1, 32'h2402000A, 0, 0));
        tbl.push_back(mk(0, 0, 0,     1, 1, 32'h40, 32'hDEADBEEF, 0, 1, 0, 1, 0, 0,           0, 0));
        tbl.push_back(mk(0, 0, 0,     1, 0, 32'h40, 0,           0, 1, 0, 1, 0, 0,            1, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0,            0, 0, 0, 1, 0, 0,            1, 32'hDEADBEEF));
        // Both held: data wins LIMIT times, then fetch, then pattern restarts.
        tbl.push_back(mk(0, 1, 32'h10, 1, 0, 32'h40, 0,          0, 1, 1, 1, 0, 0,            0, 0));
        tbl.push_back(mk(0, 1, 32'h10, 1, 0, 32'h40, 0,          0, 1, 1, 1, 0, 0,            1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 32'h10, 1, 0, 32'h40, 0,          0, 1, 1, 1, 0, 0,            1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 32'h10, 1, 0, 32'h40, 0,          0, 1, 1, 1, 0, 0,            1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 32'h10, 1, 0, 32'h40, 0,          1, 0, 0, 1, 0, 0,            1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 32'h10, 1, 0, 32'h40, 0,          0, 1, 1, 1, 1, 32'h2402000A, 0, 0));
        // Alternating single requests: a grant and a valid every cycle.
        tbl.push_back(mk(0, 1, 32'h10, 0, 0, 0,     0,           1, 0, 0, 1, 0, 0,            1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 0,     1, 0, 32'h40, 0,           0, 1, 0, 1, 1, 32'h2402000A, 0, 0));
        tbl.push_back(mk(0, 1, 32'h10, 0, 0, 0,     0,           1, 0, 0, 1, 0, 0,            1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0,            0, 0, 0, 1, 1, 32'h2402000A, 0, 0));
        foreach (tbl[t]) run_cycle(tbl[t]);

        // Reset in the cycle after a fetch grant drops the response.
        run_cycle(mk(0, 1, 32'h10, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        run_cycle(mk(1, 0, 0,      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        run_cycle(mk(1, 0, 0,      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        run_cycle(mk(0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // Grant issued while reset is high never produces a response.
        run_cycle(mk(1, 1, 32'h10, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        run_cycle(mk(0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        // Fetch drops after 3 denials: count restarts, data wins 4 more conflicts.
        for (int k = 0; k < 3; k++) run_cycle(mk(0, 1, 32'h10, 1, 0, 32'h40, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        run_cycle(mk(0, 0, 0, 1, 0, 32'h40, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) run_cycle(mk(0, 1, 32'h10, 1, 0, 32'h40, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        run_cycle(mk(0, 1, 32'h10, 1, 0, 32'h40, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        // Random traffic; each requester holds its request until granted.
        pi = 0; pd = 0; rwe = 0; ria = 0; rda = 0; rdw = 0;
        for (int k = 0; k < 400; k++) begin
            if (!pi && $urandom_range(0, 3) != 0) begin
                pi = 1; ria = {22'd0, 8'($urandom_range(0, 31)), 2'b00};
            end
            if (!pd && $urandom_range(0, 2) != 0) begin
                pd = 1; rwe = 1'($urandom_range(0, 1));
                rda = {22'd0, 8'($urandom_range(0, 31)), 2'b00}; rdw = $urandom;
            end
            r = '0;
            r.rst = ($urandom_range(0, 59) == 0);
            r.i_req = pi; r.i_addr = pi ? ria : 32'd0;
            r.d_req = pd; r.d_we = pd & rwe; r.d_addr = pd ? rda : 32'd0;
            r.d_wdata = pd ? rdw : 32'd0;
            run_cycle(r);
            if (last_ig) pi = 0;
            if (last_dg) pd = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that lets the instruction-fetch stage and the MEM stage share one synchronous unified RAM. Each cycle it grants at most one access. Data accesses have priority, and a starvation counter guarantees fetch progress. It also produces the pipeline stall that freezes the PC when fetch loses arbitration. It sits between the CPU core's IF/MEM memory ports and the external RAM.

## Interface
Parameters:
- STARVE_LIMIT, 4: number of consecutive denied fetch cycles after which fetch wins the next conflict; legal range 1–15.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- iReq  in  1  fetch request (from romCe)
- iAddr  in  32  fetch address
- iGnt  out  1  fetch granted this cycle
- iValid  out  1  fetch read data valid (cycle after grant)
- iData  out  32  fetch read data
- dReq  in  1  data request (from memCe)
- dWe  in  1  1 = write, 0 = read
- dAddr  in  32  data address
- dWData  in  32  write data
- dGnt  out  1  data granted this cycle
- dValid  out  1  read data valid / write acknowledged (cycle after grant)
- dRData  out  32  data read data
- ramCe  out  1  RAM enable
- ramWe  out  1  RAM write enable
- ramAddr  out  32  RAM address
- ramWData  out  32  RAM write data
- ramRData  in  32  RAM read data, valid one cycle after a read enable
- stall  out  1  freeze IF/PC; equals iReq & ~iGnt

## Operation
- Grant logic is combinational within the cycle:
  - dReq only: data granted.
  - iReq only: fetch granted.
  - Both, starveCnt < STARVE_LIMIT: data granted.
  - Both, starveCnt == STARVE_LIMIT: fetch granted.
- The RAM port is driven combinationally from the granted requester: ramCe=1, ramAddr, ramWe=dWe&dGnt, ramWData=dWData.
- With no grant: ramCe=0, ramWe=0. ramAddr and ramWData are 0.
- Owner register, 2-bit FSM, updated every edge: NONE, FETCH, DRD, DWR. The next value is the access granted this cycle, or NONE if nothing was granted.
- Response cycle, by owner:
  - FETCH: iValid=1, iData=ramRData.
  - DRD: dValid=1, dRData=ramRData.
  - DWR: dValid=1, dRData=0.
  - NONE: both valids 0.
- Read-data outputs are 0 when their valid is 0.
- starveCnt (4-bit): increments on each cycle with iReq & ~iGnt and saturates at STARVE_LIMIT. It clears on any fetch grant and on any cycle with iReq=0.
- Addresses pass through unmodified; no alignment checks.

## Timing
- Reset values: owner=NONE, starveCnt=0, iValid=dValid=0, iData=dRData=0. Grant, RAM and stall outputs follow the combinational rules, so they are 0 while inputs are idle.
- Latency: grant in cycle N gives valid in cycle N+1. Back-to-back grants are allowed every cycle, for full throughput.
- A requester must hold req/addr/data stable until it sees its grant. Grant consumes the request.
- Simultaneous grant and response in one cycle is normal: a new access is issued while the previous response is returned.
- Reset asserted while an access is outstanding: the response is dropped and no valid appears the cycle after reset.
- A write granted in cycle N is visible to a read granted in N+1 (RAM write-first not required; separate cycles).
- The stall output is purely combinational and has no registered delay.

## Structure
- The shared definitions package holds the owner encodings (OWN_NONE, OWN_FETCH, OWN_DRD, OWN_DWR) and the STARVE_LIMIT default constant.
- One sub-module is natural: arb_starve_ctr (the saturating counter plus its compare-to-limit output). The FSM, muxing and response logic stay in mem_arbiter.

## Test plan
- Reset, then iReq=1, iAddr=0x10, RAM word 0x10=0x2402000A → iGnt=1 and stall=0 in cycle 1; iValid=1, iData=0x2402000A in cycle 2.
- dReq=1, dWe=1, dAddr=0x40, dWData=0xDEADBEEF, then a read of 0x40 → ramWe=1 in cycle 1, dValid=1 in cycle 2; the read returns 0xDEADBEEF with dValid the next cycle.
- iReq and dReq held high together, STARVE_LIMIT=4 → data granted 4 cycles with stall=1, then fetch granted in cycle 5 and starveCnt=0. The pattern repeats.
- Alternating single requests every cycle (I, D, I, D) → a grant every cycle and a valid every cycle from cycle 2 on, each on the correct port.
- rst asserted in the cycle after a fetch grant → iValid stays 0 and owner=NONE; no RAM enable while rst holds with inputs idle.
- iReq drops after 3 denied cycles and rises again → starveCnt restarts from 0, so data still wins 4 more conflicts.
